// File: rtl/instruction_stream_sequencer.sv
// Buffers a host-loaded program and issues it to the cpu one word per clock,
// with stall, sentinel/length termination, replay and clear.
module instruction_stream_sequencer #(
    parameter int                     DEPTH       = 1024,
    parameter int                     ADDR_WIDTH  = 10,
    parameter int                     INSTR_WIDTH = 16,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = 16'hFFFF,
    parameter logic [INSTR_WIDTH-1:0] IDLE_WORD   = 16'h0009
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   load_valid_in,
    input  logic [INSTR_WIDTH-1:0] load_data_in,
    output logic                   load_ready_out,
    input  logic                   start_in,
    input  logic                   clear_in,
    input  logic                   stall_in,
    output logic [INSTR_WIDTH-1:0] current_instruction,
    output logic                   instruction_valid_out,
    output logic [ADDR_WIDTH-1:0]  pc_out,
    output logic [ADDR_WIDTH:0]    program_length_out,
    output logic [ADDR_WIDTH:0]    issued_count_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   overflow_error_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH + 1)'(1);

    state_t                  state, state_next;
    logic [INSTR_WIDTH-1:0]  mem [DEPTH];
    logic [INSTR_WIDTH-1:0]  rd_data;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [ADDR_WIDTH:0]     wr_ptr;
    logic [ADDR_WIDTH:0]     pc;
    logic [ADDR_WIDTH:0]     pc_inc;
    logic                    load_accept;
    logic                    overflow_hit;
    logic                    clear_go;
    logic                    start_run;
    logic                    issue;

    assign pc_inc             = pc + ONE;
    assign load_ready_out     = (state == S_IDLE) && (wr_ptr < DEPTH_W);
    assign busy_out           = (state == S_FETCH) || (state == S_RUN);
    assign done_out           = (state == S_DONE);
    assign program_length_out = wr_ptr;

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        load_accept  = 1'b0;
        overflow_hit = 1'b0;
        clear_go     = 1'b0;
        start_run    = 1'b0;
        issue        = 1'b0;
        rd_addr      = pc[ADDR_WIDTH-1:0];
        case (state)
            S_IDLE: begin
                load_accept  = load_valid_in && (wr_ptr < DEPTH_W);
                overflow_hit = load_valid_in && (wr_ptr == DEPTH_W);
                if (clear_in) begin
                    clear_go = 1'b1;
                end else if (start_in) begin
                    start_run  = 1'b1;
                    state_next = ((wr_ptr == '0) && !load_accept) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                // Length is checked first: past the end, rd_data is not a program word.
                if (!stall_in) begin
                    if ((pc == wr_ptr) || (rd_data == HALT_WORD)) begin
                        state_next = S_DONE;
                    end else begin
                        issue   = 1'b1;
                        rd_addr = pc_inc[ADDR_WIDTH-1:0];
                    end
                end
            end
            S_DONE: begin
                if (clear_in) begin
                    clear_go   = 1'b1;
                    state_next = S_IDLE;
                end else if (start_in) begin
                    start_run  = 1'b1;
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A word accepted alongside clear becomes the first word of the new program.
    assign wr_addr = clear_go ? '0 : wr_ptr[ADDR_WIDTH-1:0];

    always_ff @(posedge clock_in) begin
        if (load_accept) begin
            mem[wr_addr] <= load_data_in;
        end
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            wr_ptr                <= '0;
            pc                    <= '0;
            current_instruction   <= IDLE_WORD;
            instruction_valid_out <= 1'b0;
            pc_out                <= '0;
            issued_count_out      <= '0;
            overflow_error_out    <= 1'b0;
        end else begin
            if (clear_go) begin
                wr_ptr <= load_accept ? ONE : '0;
            end else if (load_accept) begin
                wr_ptr <= wr_ptr + ONE;
            end

            if (clear_go) begin
                overflow_error_out <= 1'b0;
            end else if (overflow_hit) begin
                overflow_error_out <= 1'b1;
            end

            if (start_run) begin
                pc               <= '0;
                issued_count_out <= '0;
            end else if (issue) begin
                pc               <= pc_inc;
                issued_count_out <= issued_count_out + ONE;
            end

            instruction_valid_out <= issue;
            current_instruction   <= issue ? rd_data : IDLE_WORD;
            if (issue) begin
                pc_out <= pc[ADDR_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_instruction_stream_sequencer.sv
// Directed bench for instruction_stream_sequencer: sentinel and length
// termination, replay, stall, reset mid-run, empty program and full memory.
module tb_instruction_stream_sequencer;

    logic        clock_in;
    logic        reset_in;
    logic        load_valid_in;
    logic [15:0] load_data_in;
    logic        load_ready_out;
    logic        start_in;
    logic        clear_in;
    logic        stall_in;
    logic [15:0] current_instruction;
    logic        instruction_valid_out;
    logic [9:0]  pc_out;
    logic [10:0] program_length_out;
    logic [10:0] issued_count_out;
    logic        busy_out;
    logic        done_out;
    logic        overflow_error_out;

    int n_cmp;
    int n_bad;

    instruction_stream_sequencer #(
        .DEPTH       (1024),
        .ADDR_WIDTH  (10),
        .INSTR_WIDTH (16),
        .HALT_WORD   (16'hFFFF),
        .IDLE_WORD   (16'h0009)
    ) dut (
        .clock_in              (clock_in),
        .reset_in              (reset_in),
        .load_valid_in         (load_valid_in),
        .load_data_in          (load_data_in),
        .load_ready_out        (load_ready_out),
        .start_in              (start_in),
        .clear_in              (clear_in),
        .stall_in              (stall_in),
        .current_instruction   (current_instruction),
        .instruction_valid_out (instruction_valid_out),
        .pc_out                (pc_out),
        .program_length_out    (program_length_out),
        .issued_count_out      (issued_count_out),
        .busy_out              (busy_out),
        .done_out              (done_out),
        .overflow_error_out    (overflow_error_out)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w);
        load_valid_in = 1'b1;
        load_data_in  = w;
        tick();
        load_valid_in = 1'b0;
    endtask

    task automatic pulse_start();
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input logic [15:0] w, input logic [9:0] pc);
        check({tag, "_valid"}, 32'(instruction_valid_out), 32'(1'b1));
        check({tag, "_word"},  32'(current_instruction),   32'(w));
        check({tag, "_pc"},    32'(pc_out),                32'(pc));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, "_valid"}, 32'(instruction_valid_out), 32'(1'b0));
        check({tag, "_word"},  32'(current_instruction),   32'(16'h0009));
    endtask

    initial begin
        int cnt;
        bit order_ok;
        logic [15:0] w3 [3];
        logic [15:0] w5 [5];
        w3[0] = 16'h0101; w3[1] = 16'h0202; w3[2] = 16'h0303;
        w5[0] = 16'h0011; w5[1] = 16'h0022; w5[2] = 16'h0033;
        w5[3] = 16'h0044; w5[4] = 16'h0055;

        n_cmp = 0;
        n_bad = 0;
        reset_in      = 1'b1;
        load_valid_in = 1'b0;
        load_data_in  = '0;
        start_in      = 1'b0;
        clear_in      = 1'b0;
        stall_in      = 1'b0;
        tick();
        tick();
        expect_idle("rst");
        check("rst_busy",   32'(busy_out),           32'(1'b0));
        check("rst_done",   32'(done_out),           32'(1'b0));
        check("rst_len",    32'(program_length_out), 32'(0));
        check("rst_issued", 32'(issued_count_out),   32'(0));
        check("rst_ovf",    32'(overflow_error_out), 32'(1'b0));
        check("rst_ready",  32'(load_ready_out),     32'(1'b1));
        reset_in = 1'b0;

        // Sentinel terminates; the word after it is never issued.
        load_word(16'h1234);
        load_word(16'h0A21);
        load_word(16'hFFFF);
        load_word(16'h5555);
        check("t1_len", 32'(program_length_out), 32'(4));
        pulse_start();
        check("t1_busy_fetch", 32'(busy_out), 32'(1'b1));
        check("t1_ready_busy", 32'(load_ready_out), 32'(1'b0));
        tick();
        expect_idle("t1_lat1");
        tick();
        expect_issue("t1_w0", 16'h1234, 10'd0);
        tick();
        expect_issue("t1_w1", 16'h0A21, 10'd1);
        tick();
        expect_idle("t1_halt");
        check("t1_done",   32'(done_out),         32'(1'b1));
        check("t1_issued", 32'(issued_count_out), 32'(2));
        tick();
        expect_idle("t1_after");

        // Length termination, then replay with identical latency.
        pulse_clear();
        check("t2_ready", 32'(load_ready_out),     32'(1'b1));
        check("t2_len0",  32'(program_length_out), 32'(0));
        check("t2_done0", 32'(done_out),           32'(1'b0));
        for (int i = 0; i < 3; i++) load_word(w3[i]);
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            check("t2_issued_rst", 32'(issued_count_out), 32'(0));
            tick();
            expect_idle("t2_lat");
            for (int k = 0; k < 3; k++) begin
                tick();
                expect_issue("t2_w", w3[k], 10'(k));
            end
            tick();
            expect_idle("t2_end");
            check("t2_done",   32'(done_out),         32'(1'b1));
            check("t2_issued", 32'(issued_count_out), 32'(3));
        end

        // Two stall cycles after the second word.
        pulse_clear();
        for (int i = 0; i < 5; i++) load_word(w5[i]);
        pulse_start();
        tick();
        tick();
        expect_issue("t3_w0", w5[0], 10'd0);
        tick();
        expect_issue("t3_w1", w5[1], 10'd1);
        stall_in = 1'b1;
        tick();
        expect_idle("t3_stall0");
        check("t3_busy", 32'(busy_out), 32'(1'b1));
        tick();
        expect_idle("t3_stall1");
        stall_in = 1'b0;
        for (int k = 2; k < 5; k++) begin
            tick();
            expect_issue("t3_w", w5[k], 10'(k));
        end
        tick();
        expect_idle("t3_end");
        check("t3_done",   32'(done_out),         32'(1'b1));
        check("t3_issued", 32'(issued_count_out), 32'(5));

        // Reset mid-run after four issues.
        pulse_clear();
        for (int i = 0; i < 5; i++) load_word(w5[i]);
        load_word(16'h0066);
        pulse_start();
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            expect_issue("t4_w", w5[k], 10'(k));
        end
        check("t4_issued4", 32'(issued_count_out), 32'(4));
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        expect_idle("t4_rst");
        check("t4_busy", 32'(busy_out),           32'(1'b0));
        check("t4_len",  32'(program_length_out), 32'(0));

        // Empty program goes straight to DONE.
        pulse_start();
        check("t5_done",   32'(done_out),         32'(1'b1));
        check("t5_busy",   32'(busy_out),         32'(1'b0));
        check("t5_issued", 32'(issued_count_out), 32'(0));
        expect_idle("t5_idle");
        tick();
        expect_idle("t5_idle2");
        pulse_clear();
        check("t5_ready", 32'(load_ready_out), 32'(1'b1));
        check("t5_ndone", 32'(done_out),       32'(1'b0));

        // Full memory, overflow, and a full-length run without wrap-around.
        load_valid_in = 1'b1;
        load_data_in  = 16'h0009;
        for (int i = 0; i < 1024; i++) tick();
        load_valid_in = 1'b0;
        check("t6_len",      32'(program_length_out), 32'(1024));
        check("t6_ready0",   32'(load_ready_out),     32'(1'b0));
        check("t6_ovf_pre",  32'(overflow_error_out), 32'(1'b0));
        load_word(16'h7777);
        check("t6_ovf",      32'(overflow_error_out), 32'(1'b1));
        check("t6_len_hold", 32'(program_length_out), 32'(1024));
        check("t6_ready1",   32'(load_ready_out),     32'(1'b0));
        pulse_start();
        cnt      = 0;
        order_ok = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (instruction_valid_out) begin
                if (pc_out != 10'(cnt) || current_instruction != 16'h0009) order_ok = 1'b0;
                cnt++;
            end
            if (done_out) break;
        end
        check("t6_done",   32'(done_out),         32'(1'b1));
        check("t6_count",  32'(cnt),              32'(1024));
        check("t6_order",  32'(order_ok),         32'(1'b1));
        check("t6_issued", 32'(issued_count_out), 32'(1024));
        check("t6_lastpc", 32'(pc_out),           32'(1023));
        check("t6_ovf_kept", 32'(overflow_error_out), 32'(1'b1));
        pulse_clear();
        check("t6_ovf_clr", 32'(overflow_error_out), 32'(1'b0));
        check("t6_len_clr", 32'(program_length_out), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_stream_sequencer.md
Name: instruction_stream_sequencer

Overview:
- Synthesizable instruction source for `cpu`: buffers a program of 16-bit words, then drives `current_instruction` one word per clock.
- Replaces the simulation-only loop that walks `machine_code` until the 16'hFFFF sentinel.
- Sits between a host or loader and `cpu.current_instruction`.
- Supports a stall, sentinel or length termination, replay, and clear.

Parameters:
- DEPTH, 1024: program memory words.
- ADDR_WIDTH, 10: log2(DEPTH).
- INSTR_WIDTH, 16: instruction width.
- HALT_WORD, 16'hFFFF: end-of-program sentinel; never issued to the cpu.
- IDLE_WORD, 16'h0009: word driven whenever no valid instruction is issued (NOP opcode 4'b1001 in bits [3:0]).

Ports:
- clock_in  in  1  system clock; all state updates on the rising edge.
- reset_in  in  1  synchronous, active-high reset.
- load_valid_in  in  1  host presents a program word.
- load_data_in  in  INSTR_WIDTH  program word.
- load_ready_out  out  1  word is accepted this cycle when valid and ready are both high.
- start_in  in  1  begin or replay execution from address 0.
- clear_in  in  1  discard the loaded program (length set to 0).
- stall_in  in  1  hold issue; the downstream is not ready.
- current_instruction  out  INSTR_WIDTH  instruction to the cpu.
- instruction_valid_out  out  1  current_instruction is a real program word.
- pc_out  out  ADDR_WIDTH  address of the word currently issued.
- program_length_out  out  ADDR_WIDTH+1  words loaded.
- issued_count_out  out  ADDR_WIDTH+1  valid words issued in the current or last run.
- busy_out  out  1  FETCH or RUN.
- done_out  out  1  in DONE.
- overflow_error_out  out  1  sticky; a load was attempted while memory was full.

Behaviour:
- Reset (synchronous, reset_in high at the edge):
  - State IDLE; wr_ptr=0; pc=0.
  - current_instruction=IDLE_WORD; all valid, busy, done and error flags=0; counts=0.
  - Memory contents are not cleared but are unreachable, since length=0.
  - Reset in any state, mid-run included, aborts the run immediately.
- States: IDLE, FETCH, RUN, DONE.
- IDLE (loading):
  - load_ready_out = (wr_ptr < DEPTH).
  - On accept: mem[wr_ptr] <= load_data_in; wr_ptr += 1.
  - load_valid_in while wr_ptr==DEPTH: word dropped; overflow_error_out <= 1, cleared only by reset or clear_in.
  - load_ready_out = 0 in every state other than IDLE.
- start_in in IDLE:
  - Length 0: go to DONE next cycle with issued_count=0.
  - Otherwise: go to FETCH and set pc=0.
  - start_in and an accepted load in the same cycle: the word is written and included in the program.
- FETCH: one cycle for the synchronous memory read of address 0, then go to RUN.
  - Latency: first valid instruction appears exactly 2 cycles after the start_in edge.
- RUN (issue rules):
  - Each cycle: instruction_valid_out=1 and current_instruction=mem[pc]; pc_out=pc.
  - Advance to the next address every cycle.
  - Valid output words form exactly mem[0], mem[1], … in order, with no loss and no duplication.
- RUN (stall):
  - stall_in high at edge n: output after edge n is IDLE_WORD with valid=0.
  - The pending word is held internally, not re-fetched out of order.
  - It is issued on the first edge after stall_in deasserts.
  - Consecutive stall cycles extend the idle output indefinitely.
- RUN (termination):
  - The next word to issue equals HALT_WORD, or its address equals program_length.
  - That cycle outputs IDLE_WORD with valid=0, and the state becomes DONE.
  - HALT_WORD is never issued with valid=1.
  - A full 1024-word program with no sentinel terminates when the address reaches 1024, without wrap-around.
- RUN (ignored inputs): start_in and clear_in are ignored in FETCH and RUN.
- issued_count_out increments on each valid issue and resets to 0 on start.
- DONE:
  - done_out=1; output is IDLE_WORD with valid=0; memory and length are retained.
  - start_in: replay (FETCH, pc=0).
  - clear_in: wr_ptr=0, error cleared, go to IDLE.
  - Both asserted together: clear_in wins.
- clear_in in IDLE: wr_ptr=0 and error cleared.
- busy_out = FETCH or RUN.
- Outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Load 16'h1234, 16'h0A21, 16'hFFFF, 16'h5555 → start_in → 2 cycles later:
  - 16'h1234 valid, then 16'h0A21 valid.
  - Next cycle IDLE_WORD with valid=0 and done_out=1.
  - issued_count=2; 16'h5555 is never issued.
- Load 3 words with no sentinel → start_in:
  - Exactly 3 valid words, then DONE.
  - start_in again replays the same 3 words with the same 2-cycle latency.
- 5-word run, stall_in high for 2 cycles after the 2nd issued word:
  - Two IDLE_WORD cycles with valid=0.
  - Resumes with word 3; full sequence 1..5 with no gap or duplicate.
- Load 1024 words of 16'h0009, then a 1025th load_valid_in:
  - load_ready_out=0 and overflow_error_out=1.
  - Run issues 1024 valid words; pc does not wrap.
- reset_in asserted during RUN after 4 issues:
  - Next cycle: IDLE_WORD, valid=0, busy=0, program_length_out=0.
  - A subsequent start_in goes to DONE with issued_count=0.
- Length 0 → start_in:
  - done_out=1 the next cycle; valid stays 0.
  - clear_in returns to IDLE with load_ready_out=1.
